// File: rtl/input_mux_sequencer.sv
// Input-side bit-width mux sequencer.
// Pulls 32-bit words from the input buffer, holds each word, and steps the
// phase select through 1, 2 or 4 phases depending on the weight bitwidth,
// presenting {word, phase, bitwidth} to the mux as a valid/ready stream.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no job; waits for start (ignored during the done pulse cycle)
// FETCH | buf_ready high, waiting for the next input word
// ISSUE | word held, out_valid high, stepping phases on out_ready
module input_mux_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cfg_bitwidth,
  input  logic [CNT_W-1:0] cfg_num_words,
  output logic             busy,
  output logic             done,
  input  logic             buf_valid,
  output logic             buf_ready,
  input  logic [31:0]      buf_data,
  output logic [31:0]      mux_buffer,
  output logic [1:0]       mux_state,
  output logic [1:0]       mux_bitwidth,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       bw_q, bw_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic [31:0]      buffer_q, buffer_d;
  logic             done_q, done_d;

  logic [1:0]       last_phase;
  logic             at_last;
  logic             more_words;

  // Final phase index for the latched bitwidth (8b: 1 phase, 4b: 2, 2b: 4).
  always_comb begin
    case (bw_q)
      2'b00:   last_phase = 2'd0;
      2'b01:   last_phase = 2'd1;
      default: last_phase = 2'd3;
    endcase
  end

  assign at_last    = (phase_q == last_phase);
  assign more_words = (words_left_q > CNT_W'(1));

  // Next-state, datapath-load and handshake decode.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bw_d         = bw_q;
    words_left_d = words_left_q;
    buffer_d     = buffer_q;
    done_d       = 1'b0;
    buf_ready    = 1'b0;
    out_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q high means the previous job just finished; a start landing
        // on that cycle is treated as arriving while still busy.
        if (start && !done_q) begin
          bw_d         = cfg_bitwidth;
          words_left_d = cfg_num_words;
          if (cfg_num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        buf_ready = 1'b1;
        if (buf_valid) begin
          buffer_d = buf_data;
          phase_d  = 2'd0;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!at_last) begin
            phase_d = phase_q + 2'd1;
          end else begin
            words_left_d = words_left_q - CNT_W'(1);
            if (!more_words) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              // Accepting the next word on the final-phase handshake keeps
              // the output stream free of bubbles.
              buf_ready = 1'b1;
              if (buf_valid) begin
                buffer_d = buf_data;
                phase_d  = 2'd0;
              end else begin
                state_d = FETCH;
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= 2'd0;
      bw_q         <= 2'd0;
      words_left_q <= '0;
      buffer_q     <= 32'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bw_q         <= bw_d;
      words_left_q <= words_left_d;
      buffer_q     <= buffer_d;
      done_q       <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign mux_buffer   = buffer_q;
  assign mux_state    = phase_q;
  assign mux_bitwidth = bw_q;
  assign out_last     = out_valid & at_last & (words_left_q == CNT_W'(1));

endmodule

// File: tb/tb_input_mux_sequencer.sv
// Testbench for input_mux_sequencer: each job is checked cycle by cycle
// against a queue of expected {word, phase} outputs built from the words
// the buffer hands over.
module tb_input_mux_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       cfg_bitwidth;
  logic [CNT_W-1:0] cfg_num_words;
  logic             busy;
  logic             done;
  logic             buf_valid;
  logic             buf_ready;
  logic [31:0]      buf_data;
  logic [31:0]      mux_buffer;
  logic [1:0]       mux_state;
  logic [1:0]       mux_bitwidth;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_mux_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_bitwidth  (cfg_bitwidth),
    .cfg_num_words (cfg_num_words),
    .busy          (busy),
    .done          (done),
    .buf_valid     (buf_valid),
    .buf_ready     (buf_ready),
    .buf_data      (buf_data),
    .mux_buffer    (mux_buffer),
    .mux_state     (mux_state),
    .mux_bitwidth  (mux_bitwidth),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last)
  );

  // Runs one job. Inputs change on the falling edge; outputs are sampled 1
  // time unit later, so the sample reflects the handshake taken at the next
  // rising edge. The model is a queue of pending {word, phase} outputs.
  task automatic drive_job(input string name, input logic [1:0] bw, input int n,
                           input int vprob, input int rprob, input bit toggle,
                           input int gap, input bit start_every);
    int          lp, total, cyc, accepted, n_out, expect_done, gap_left;
    int          first_cyc, last_cyc;
    logic [31:0] words[$];
    logic [31:0] q_word[$];
    int          q_phase[$];
    bit          exp_busy, exp_rdy;

    lp    = (bw == 2'd0) ? 0 : (bw == 2'd1) ? 1 : 3;
    total = n * (lp + 1);
    for (int i = 0; i < n; i++) words.push_back($urandom);

    @(negedge clk);
    start = 1'b1; cfg_bitwidth = bw; cfg_num_words = CNT_W'(n);
    buf_valid = 1'b0; out_ready = 1'b0; buf_data = 32'd0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || buf_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_cycle: busy=%b buf_ready=%b, want 0 0", name, busy, buf_ready);
    end

    cyc = 0; accepted = 0; n_out = 0; gap_left = 0;
    first_cyc = -1; last_cyc = -1;
    expect_done = (n == 0) ? 1 : -1;

    do begin
      @(negedge clk);
      cyc++;
      start         = start_every;
      cfg_bitwidth  = 2'($urandom);
      cfg_num_words = CNT_W'($urandom_range(0, 9));
      if (gap_left > 0) begin
        buf_valid = 1'b0;
        gap_left--;
      end else begin
        buf_valid = ($urandom_range(0, 99) < vprob);
      end
      buf_data  = (accepted < n) ? words[accepted] : $urandom;
      out_ready = toggle ? cyc[0] : ($urandom_range(0, 99) < rprob);
      #1;

      exp_busy = !(accepted == n && q_word.size() == 0);
      exp_rdy  = (accepted < n) && (q_word.size() == 0 || (q_word.size() == 1 && out_ready));

      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy @%0d: got %b want %b", name, cyc, busy, exp_busy);
      end
      n_checks++;
      if (done !== (cyc == expect_done)) begin
        n_fail++;
        $display("FAIL %s done @%0d: got %b want %b", name, cyc, done, cyc == expect_done);
      end
      n_checks++;
      if (buf_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s buf_ready @%0d: got %b want %b", name, cyc, buf_ready, exp_rdy);
      end
      n_checks++;
      if (out_valid !== (q_word.size() != 0)) begin
        n_fail++;
        $display("FAIL %s out_valid @%0d: got %b want %b", name, cyc, out_valid, q_word.size() != 0);
      end

      if (q_word.size() != 0) begin
        n_checks++;
        if (mux_buffer !== q_word[0] || mux_state !== 2'(q_phase[0]) || mux_bitwidth !== bw) begin
          n_fail++;
          $display("FAIL %s mux_out @%0d: got %h/%0d/%0d want %h/%0d/%0d", name, cyc,
                   mux_buffer, mux_state, mux_bitwidth, q_word[0], q_phase[0], bw);
        end
        n_checks++;
        if (out_last !== (n_out == total - 1)) begin
          n_fail++;
          $display("FAIL %s out_last @%0d: got %b want %b", name, cyc, out_last, n_out == total - 1);
        end
        if (out_ready) begin
          void'(q_word.pop_front());
          void'(q_phase.pop_front());
          n_out++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (n_out == total) expect_done = cyc + 1;
        end
      end else begin
        n_checks++;
        if (out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL %s out_last_idle @%0d: got %b want 0", name, cyc, out_last);
        end
      end

      if (buf_valid && exp_rdy) begin
        for (int p = 0; p <= lp; p++) begin
          q_word.push_back(words[accepted]);
          q_phase.push_back(p);
        end
        accepted++;
        if (accepted == 1) gap_left = gap;
      end
    end while (cyc != expect_done && cyc < 3000);

    if (cyc != expect_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
    end

    n_checks++;
    if (n_out != total) begin
      n_fail++;
      $display("FAIL %s output_count: got %0d want %0d", name, n_out, total);
    end

    if (vprob == 100 && rprob == 100 && !toggle && gap == 0 && n > 0) begin
      n_checks++;
      if (last_cyc - first_cyc != total - 1) begin
        n_fail++;
        $display("FAIL %s throughput_span: got %0d want %0d", name, last_cyc - first_cyc, total - 1);
      end
    end

    @(negedge clk);
    start = 1'b0; buf_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || buf_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: busy=%b done=%b buf_ready=%b, want 0 0 0", name, busy, done, buf_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg_bitwidth = 2'd3; cfg_num_words = 16'd5;
    buf_valid = 1'b1; buf_data = 32'hdeadbeef; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, buf_ready, out_valid, out_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, buf_ready, out_valid, out_last});
    end
    n_checks++;
    if (mux_buffer !== 32'd0 || mux_state !== 2'd0 || mux_bitwidth !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mux: got %h/%0d/%0d want 0/0/0", mux_buffer, mux_state, mux_bitwidth);
    end
    reset = 1'b0; buf_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_single_phase();
    drive_job("t1_bw8", 2'd0, 3, 100, 100, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_bubble();
    drive_job("t2_bw4", 2'd1, 2, 100, 100, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    drive_job("t3_toggle", 2'd2, 1, 100, 100, 1'b1, 0, 1'b0);
  endtask

  task automatic test_fetch_gap();
    drive_job("t4_gap", 2'd3, 2, 100, 100, 1'b0, 5, 1'b0);
  endtask

  task automatic test_zero_and_restart();
    drive_job("t5_zero", 2'd1, 0, 100, 100, 1'b0, 0, 1'b0);
    drive_job("t5_zero_start_held", 2'd2, 0, 100, 100, 1'b0, 0, 1'b1);
    drive_job("t5_start_busy", 2'd1, 3, 70, 70, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    int hs;
    bit hit;
    hs = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_bitwidth = 2'd2; cfg_num_words = 16'd4;
    buf_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0; buf_valid = 1'b1; buf_data = $urandom; out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1 && hs == 6) begin
        hit = 1'b1;
        n_checks++;
        if (mux_state !== 2'd2) begin
          n_fail++;
          $display("FAIL t6_reset_point: got phase %0d want 2", mux_state);
        end
        reset = 1'b1;
      end else if (out_valid === 1'b1) begin
        hs++;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL t6_reach: got %0d outputs, want 6 before reset", hs);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, buf_ready, out_valid, out_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL t6_ctrl: got %b want 00000", {busy, done, buf_ready, out_valid, out_last});
    end
    n_checks++;
    if (mux_buffer !== 32'd0 || mux_state !== 2'd0 || mux_bitwidth !== 2'd0) begin
      n_fail++;
      $display("FAIL t6_mux: got %h/%0d/%0d want 0/0/0", mux_buffer, mux_state, mux_bitwidth);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      buf_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_quiet: got done=%b busy=%b out_valid=%b want 0 0 0", done, busy, out_valid);
      end
    end
    buf_valid = 1'b0; out_ready = 1'b0;
    drive_job("t6_fresh", 2'd2, 4, 100, 100, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 10; j++) begin
      drive_job("random", 2'($urandom), $urandom_range(1, 6), $urandom_range(30, 100),
                $urandom_range(30, 100), 1'b0, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_phase();
    test_zero_bubble();
    test_stall();
    test_fetch_gap();
    test_zero_and_restart();
    test_reset_mid_job();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
